kyber_dma_master: RTL and testbench

AXI4 burst initiator that moves Kyber operand buffers (pk, sk, c) between system memory and a local 128-bit chunk memory port, the same port style the Kyber chunk RAMs expose on their A side. It is the master end of the AXI4 interface the Kyber core already serves as a slave: system memory is read into local RAM before an operation, and local results are written back to memory afterwards. One command moves one INCR burst of 1–256 beats in one direction.

---
 rtl/kyber_dma_master.sv | 211 +++++++++++++++++++++
 tb/tb_kyber_dma_master.sv | 418 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/kyber_dma_master.sv
// AXI4 burst initiator moving 128-bit chunks between system memory and a local chunk RAM port.
// One command is one INCR burst of 1-256 beats: read (memory to local) or write (local to memory).
`timescale 1ns/1ps

module kyber_dma_master #(
  parameter int ADDR_W = 32,
  parameter int LOC_AW = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              dir,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [8:0]        beats,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              loc_en,
  output logic              loc_we,
  output logic [LOC_AW-1:0] loc_addr,
  output logic [127:0]      loc_wdata,
  input  logic [127:0]      loc_rdata,
  output logic [ADDR_W-1:0] m_axi_araddr,
  output logic [7:0]        m_axi_arlen,
  output logic [2:0]        m_axi_arsize,
  output logic [1:0]        m_axi_arburst,
  output logic              m_axi_arvalid,
  input  logic              m_axi_arready,
  input  logic [127:0]      m_axi_rdata,
  input  logic [1:0]        m_axi_rresp,
  input  logic              m_axi_rlast,
  input  logic              m_axi_rvalid,
  output logic              m_axi_rready,
  output logic [ADDR_W-1:0] m_axi_awaddr,
  output logic [7:0]        m_axi_awlen,
  output logic [2:0]        m_axi_awsize,
  output logic [1:0]        m_axi_awburst,
  output logic              m_axi_awvalid,
  input  logic              m_axi_awready,
  output logic [127:0]      m_axi_wdata,
  output logic [15:0]       m_axi_wstrb,
  output logic              m_axi_wlast,
  output logic              m_axi_wvalid,
  input  logic              m_axi_wready,
  input  logic [1:0]        m_axi_bresp,
  input  logic              m_axi_bvalid,
  output logic              m_axi_bready
);

  typedef enum logic [2:0] {
    S_IDLE, S_RD_ADDR, S_RD_DATA, S_WR_ADDR, S_WR_DATA, S_WR_RESP, S_DONE
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] base_q;
  logic [8:0]        beats_q;
  logic [8:0]        last_idx;
  logic [8:0]        rd_cnt;
  logic [8:0]        fetch_cnt;
  logic [8:0]        wr_cnt;

  logic [127:0]      fifo_mem [2];
  logic              fifo_wp;
  logic              fifo_rp;
  logic [1:0]        fifo_cnt;
  logic              in_flight;

  logic              rd_hs;
  logic              w_hs;
  logic              wr_phase;
  logic              fetch_go;

  assign last_idx      = beats_q - 9'd1;

  assign m_axi_araddr  = base_q;
  assign m_axi_arlen   = last_idx[7:0];
  assign m_axi_arsize  = 3'b100;
  assign m_axi_arburst = 2'b01;
  assign m_axi_awaddr  = base_q;
  assign m_axi_awlen   = last_idx[7:0];
  assign m_axi_awsize  = 3'b100;
  assign m_axi_awburst = 2'b01;

  // W only opens after the AW handshake; the FIFO head is stable until popped.
  assign m_axi_wvalid  = (state == S_WR_DATA) && (fifo_cnt != 2'd0);
  assign m_axi_wdata   = fifo_mem[fifo_rp];
  assign m_axi_wlast   = m_axi_wvalid && (wr_cnt == last_idx);
  assign m_axi_wstrb   = '1;

  assign rd_hs    = m_axi_rready && m_axi_rvalid;
  assign w_hs     = m_axi_wvalid && m_axi_wready;
  assign wr_phase = (state == S_WR_ADDR) || (state == S_WR_DATA);

  // Counting the slot freed by this cycle's W pop keeps W streaming one beat per cycle.
  assign fetch_go = wr_phase && (fetch_cnt < beats_q) &&
                    (({1'b0, fifo_cnt} + {2'b00, in_flight}) < (3'd2 + {2'b00, w_hs}));

  assign loc_en    = rd_hs || fetch_go;
  assign loc_we    = rd_hs;
  assign loc_addr  = rd_hs ? rd_cnt[LOC_AW-1:0] : fetch_cnt[LOC_AW-1:0];
  assign loc_wdata = m_axi_rdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fifo_wp   <= 1'b0;
      fifo_rp   <= 1'b0;
      fifo_cnt  <= 2'd0;
      in_flight <= 1'b0;
    end else begin
      in_flight <= fetch_go;
      if (in_flight) fifo_wp <= ~fifo_wp;
      if (w_hs)      fifo_rp <= ~fifo_rp;
      fifo_cnt <= fifo_cnt + {1'b0, in_flight} - {1'b0, w_hs};
    end
  end

  // NOTE: the data array is deliberately not reset; occupancy comes from the reset pointers.
  always_ff @(posedge clk) begin
    if (in_flight) fifo_mem[fifo_wp] <= loc_rdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S_IDLE;
      base_q        <= '0;
      beats_q       <= '0;
      rd_cnt        <= '0;
      fetch_cnt     <= '0;
      wr_cnt        <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      err           <= 1'b0;
      m_axi_arvalid <= 1'b0;
      m_axi_awvalid <= 1'b0;
      m_axi_rready  <= 1'b0;
      m_axi_bready  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (fetch_go) fetch_cnt <= fetch_cnt + 9'd1;
      if (w_hs)     wr_cnt    <= wr_cnt + 9'd1;
      case (state)
        S_IDLE: begin
          if (start) begin
            base_q    <= base_addr;
            beats_q   <= beats;
            err       <= 1'b0;
            rd_cnt    <= '0;
            fetch_cnt <= '0;
            wr_cnt    <= '0;
            busy      <= 1'b1;
            if (beats == 9'd0) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else if (dir) begin
              state         <= S_WR_ADDR;
              m_axi_awvalid <= 1'b1;
            end else begin
              state         <= S_RD_ADDR;
              m_axi_arvalid <= 1'b1;
            end
          end
        end
        S_RD_ADDR: begin
          if (m_axi_arready) begin
            m_axi_arvalid <= 1'b0;
            m_axi_rready  <= 1'b1;
            state         <= S_RD_DATA;
          end
        end
        S_RD_DATA: begin
          if (m_axi_rvalid) begin
            rd_cnt <= rd_cnt + 9'd1;
            // Completion follows the beat count; a misplaced rlast is only flagged.
            if ((m_axi_rresp != 2'b00) || (m_axi_rlast != (rd_cnt == last_idx))) err <= 1'b1;
            if (rd_cnt == last_idx) begin
              m_axi_rready <= 1'b0;
              state        <= S_DONE;
              done         <= 1'b1;
            end
          end
        end
        S_WR_ADDR: begin
          if (m_axi_awready) begin
            m_axi_awvalid <= 1'b0;
            state         <= S_WR_DATA;
          end
        end
        S_WR_DATA: begin
          if (w_hs && m_axi_wlast) begin
            m_axi_bready <= 1'b1;
            state        <= S_WR_RESP;
          end
        end
        S_WR_RESP: begin
          if (m_axi_bvalid) begin
            if (m_axi_bresp != 2'b00) err <= 1'b1;
            m_axi_bready <= 1'b0;
            state        <= S_DONE;
            done         <= 1'b1;
          end
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_kyber_dma_master.sv
// Bench for kyber_dma_master: bus-functional AXI slave and local RAM with queue-based scoreboards.
// Inputs are driven on the falling edge; outputs are sampled 1 ns later.
`timescale 1ns/1ps

module tb_kyber_dma_master;

  localparam int ADDR_W = 32;
  localparam int LOC_AW = 6;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              dir;
  logic [ADDR_W-1:0] base_addr;
  logic [8:0]        beats;
  logic              busy, done, err;
  logic              loc_en, loc_we;
  logic [LOC_AW-1:0] loc_addr;
  logic [127:0]      loc_wdata;
  logic [127:0]      loc_rdata = '0;
  logic [ADDR_W-1:0] m_axi_araddr, m_axi_awaddr;
  logic [7:0]        m_axi_arlen, m_axi_awlen;
  logic [2:0]        m_axi_arsize, m_axi_awsize;
  logic [1:0]        m_axi_arburst, m_axi_awburst;
  logic              m_axi_arvalid, m_axi_arready;
  logic [127:0]      m_axi_rdata;
  logic [1:0]        m_axi_rresp;
  logic              m_axi_rlast, m_axi_rvalid, m_axi_rready;
  logic              m_axi_awvalid, m_axi_awready;
  logic [127:0]      m_axi_wdata;
  logic [15:0]       m_axi_wstrb;
  logic              m_axi_wlast, m_axi_wvalid, m_axi_wready;
  logic [1:0]        m_axi_bresp;
  logic              m_axi_bvalid, m_axi_bready;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [LOC_AW-1:0] addr;
    logic [127:0]      data;
  } loc_wr_t;

  loc_wr_t      rd_sb [$];
  logic [127:0] wr_sb [$];

  kyber_dma_master #(.ADDR_W(ADDR_W), .LOC_AW(LOC_AW)) dut (
    .clk(clk), .rst(rst), .start(start), .dir(dir), .base_addr(base_addr), .beats(beats),
    .busy(busy), .done(done), .err(err),
    .loc_en(loc_en), .loc_we(loc_we), .loc_addr(loc_addr), .loc_wdata(loc_wdata), .loc_rdata(loc_rdata),
    .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen), .m_axi_arsize(m_axi_arsize),
    .m_axi_arburst(m_axi_arburst), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rlast(m_axi_rlast),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen), .m_axi_awsize(m_axi_awsize),
    .m_axi_awburst(m_axi_awburst), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready)
  );

  always #5 clk = ~clk;

  function automatic logic [127:0] rd_pat(input int b);
    return {32'hc0de_0000 + 32'(b), ~32'(b), 32'h1234_5678 ^ 32'(b), 32'(b) * 32'd3};
  endfunction

  function automatic logic [127:0] wr_pat(input int a);
    return {32'hfeed_0000 + 32'(a), 32'(a) * 32'd7, ~32'(a), 32'h0bad_0000 ^ 32'(a)};
  endfunction

  // Local chunk RAM preloaded with wr_pat; one-cycle read latency.
  always @(posedge clk) begin
    if (loc_en && !loc_we) loc_rdata <= wr_pat(int'(loc_addr));
  end

  task automatic issue(input logic d, input logic [ADDR_W-1:0] a, input logic [8:0] n);
    @(negedge clk);
    start     = 1'b1;
    dir       = d;
    base_addr = a;
    beats     = n;
  endtask

  task automatic run_read(input logic [ADDR_W-1:0] base, input int nb, input int ar_delay,
                          input int bad_beat, input int last_beat, input int inject_cyc,
                          output int nwr, output int ndone, output int done_cyc, output logic err_done);
    int      beat;
    bit      ar_seen;
    bit      stray;
    loc_wr_t exp;
    issue(1'b0, base, 9'(nb));
    nwr = 0; ndone = 0; done_cyc = -1; err_done = 1'b0;
    beat = 0; ar_seen = 1'b0; stray = 1'b0;
    rd_sb.delete();
    for (int cyc = 0; cyc < nb + ar_delay + 40; cyc++) begin
      @(negedge clk);
      start = (cyc == inject_cyc);
      if (cyc == inject_cyc) begin
        dir       = 1'b1;
        base_addr = 32'h0000_dea0;
        beats     = 9'd7;
      end
      m_axi_arready = (cyc >= ar_delay);
      m_axi_rvalid  = ar_seen && (beat < nb);
      m_axi_rdata   = rd_pat(beat);
      m_axi_rresp   = (beat == bad_beat) ? 2'b10 : 2'b00;
      m_axi_rlast   = (beat == last_beat);
      #1;
      stray = stray | m_axi_awvalid | m_axi_wvalid | (loc_en && !loc_we);
      if (m_axi_arvalid && m_axi_arready) begin
        checks++;
        if ({m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst} !== {base, 8'(nb - 1), 3'b100, 2'b01}) begin
          errors++;
          $display("FAIL ar_fields: got addr=%h len=%0d size=%0d burst=%0d, expected addr=%h len=%0d size=4 burst=1",
                   m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst, base, nb - 1);
        end
        ar_seen = 1'b1;
      end
      if (m_axi_rvalid && m_axi_rready) begin
        rd_sb.push_back('{LOC_AW'(beat), rd_pat(beat)});
        beat++;
      end
      if (loc_en && loc_we) begin
        nwr++;
        checks++;
        if (rd_sb.size() == 0) begin
          errors++;
          $display("FAIL loc_write_unexpected: got addr=%0d with no R beat pending, expected none", loc_addr);
        end else begin
          exp = rd_sb.pop_front();
          if (loc_addr !== exp.addr || loc_wdata !== exp.data) begin
            errors++;
            $display("FAIL loc_write: got addr=%0d data=%h, expected addr=%0d data=%h",
                     loc_addr, loc_wdata, exp.addr, exp.data);
          end
        end
      end
      if (done) begin
        ndone++;
        if (done_cyc < 0) begin
          done_cyc = cyc;
          err_done = err;
        end
      end
      if (done_cyc >= 0 && cyc >= done_cyc + 3) break;
    end
    m_axi_arready = 1'b0;
    m_axi_rvalid  = 1'b0;
    m_axi_rlast   = 1'b0;
    m_axi_rresp   = 2'b00;
    start         = 1'b0;
    checks++;
    if (stray || rd_sb.size() != 0) begin
      errors++;
      $display("FAIL rd_side_effects: got stray_write_activity=%0d pending_beats=%0d, expected 0 and 0",
               stray, rd_sb.size());
    end
  endtask

  task automatic run_write(input logic [ADDR_W-1:0] base, input int nb, input bit toggle,
                           input int abort_at, output int nw, output int ndone,
                           output int done_cyc, output int first_w, output logic err_done);
    bit           aw_seen, b_seen, stray, w_early, prev_stall, prev_last;
    logic [127:0] prev_data, exp;
    issue(1'b1, base, 9'(nb));
    wr_sb.delete();
    for (int i = 0; i < nb; i++) wr_sb.push_back(wr_pat(i));
    nw = 0; ndone = 0; done_cyc = -1; first_w = -1; err_done = 1'b0;
    aw_seen = 1'b0; b_seen = 1'b0; stray = 1'b0; w_early = 1'b0;
    prev_stall = 1'b0; prev_last = 1'b0; prev_data = '0;
    for (int cyc = 0; cyc < 2 * nb + 40; cyc++) begin
      @(negedge clk);
      start         = 1'b0;
      m_axi_awready = 1'b1;
      m_axi_wready  = toggle ? (cyc % 2 == 0) : 1'b1;
      m_axi_bvalid  = (nw == nb) && !b_seen;
      m_axi_bresp   = 2'b00;
      #1;
      stray   = stray | m_axi_arvalid | m_axi_rready | (loc_en && loc_we);
      w_early = w_early | (m_axi_wvalid && !aw_seen);
      if (prev_stall) begin
        checks++;
        if (!m_axi_wvalid || m_axi_wdata !== prev_data || m_axi_wlast !== prev_last) begin
          errors++;
          $display("FAIL w_hold: got valid=%0d data=%h last=%0d, expected valid=1 data=%h last=%0d",
                   m_axi_wvalid, m_axi_wdata, m_axi_wlast, prev_data, prev_last);
        end
      end
      if (m_axi_awvalid && m_axi_awready) begin
        checks++;
        if ({m_axi_awaddr, m_axi_awlen, m_axi_awsize, m_axi_awburst} !== {base, 8'(nb - 1), 3'b100, 2'b01}) begin
          errors++;
          $display("FAIL aw_fields: got addr=%h len=%0d size=%0d burst=%0d, expected addr=%h len=%0d size=4 burst=1",
                   m_axi_awaddr, m_axi_awlen, m_axi_awsize, m_axi_awburst, base, nb - 1);
        end
        aw_seen = 1'b1;
      end
      if (m_axi_wvalid && first_w < 0) first_w = cyc;
      prev_stall = m_axi_wvalid && !m_axi_wready;
      prev_data  = m_axi_wdata;
      prev_last  = m_axi_wlast;
      if (m_axi_wvalid && m_axi_wready) begin
        checks++;
        exp = (wr_sb.size() != 0) ? wr_sb.pop_front() : '0;
        if (m_axi_wdata !== exp || m_axi_wlast !== (nw == nb - 1) || m_axi_wstrb !== 16'hffff) begin
          errors++;
          $display("FAIL w_beat%0d: got data=%h last=%0d strb=%h, expected data=%h last=%0d strb=ffff",
                   nw, m_axi_wdata, m_axi_wlast, m_axi_wstrb, exp, (nw == nb - 1));
        end
        nw++;
        if (nw == abort_at) break;
      end
      if (m_axi_bvalid && m_axi_bready) b_seen = 1'b1;
      if (done) begin
        ndone++;
        if (done_cyc < 0) begin
          done_cyc = cyc;
          err_done = err;
        end
      end
      if (done_cyc >= 0 && cyc >= done_cyc + 3) break;
    end
    m_axi_awready = 1'b0;
    m_axi_wready  = 1'b0;
    m_axi_bvalid  = 1'b0;
    if (abort_at < 0) begin
      checks++;
      if (stray || w_early || !b_seen || wr_sb.size() != 0) begin
        errors++;
        $display("FAIL wr_protocol: got stray=%0d w_before_aw=%0d b_taken=%0d pending=%0d, expected 0 0 1 0",
                 stray, w_early, b_seen, wr_sb.size());
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    #1;
    checks++;
    if ({busy, done, err, loc_en, loc_we, m_axi_arvalid, m_axi_awvalid, m_axi_wvalid, m_axi_rready, m_axi_bready} !== 10'b0) begin
      errors++;
      $display("FAIL reset_outputs: got busy,done,err,en,we,arv,awv,wv,rr,br=%b, expected 0000000000",
               {busy, done, err, loc_en, loc_we, m_axi_arvalid, m_axi_awvalid, m_axi_wvalid, m_axi_rready, m_axi_bready});
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: got busy=%0d done=%0d, expected 0 0", busy, done);
    end
  endtask

  task automatic test_read_burst();
    int nwr, nd, dc;
    logic e;
    run_read(32'h0000_1000, 50, 3, -1, 49, -1, nwr, nd, dc, e);
    checks++;
    if (nwr != 50 || nd != 1 || dc != 54 || e !== 1'b0) begin
      errors++;
      $display("FAIL read50: got writes=%0d dones=%0d done_cyc=%0d err=%0d, expected 50 1 54 0", nwr, nd, dc, e);
    end
  endtask

  task automatic test_write_burst();
    int nw, nd, dc, fw;
    logic e;
    run_write(32'h0002_0000, 48, 1'b1, -1, nw, nd, dc, fw, e);
    checks++;
    if (nw != 48 || nd != 1 || fw != 2 || e !== 1'b0) begin
      errors++;
      $display("FAIL write48: got beats=%0d dones=%0d first_w_cyc=%0d err=%0d, expected 48 1 2 0", nw, nd, fw, e);
    end
  endtask

  task automatic test_read_slverr();
    int nwr, nd, dc;
    logic e;
    run_read(32'h0000_3000, 8, 0, 3, 7, -1, nwr, nd, dc, e);
    checks++;
    if (nwr != 8 || nd != 1 || dc != 9 || e !== 1'b1 || err !== 1'b1) begin
      errors++;
      $display("FAIL read_slverr: got writes=%0d dones=%0d done_cyc=%0d err_at_done=%0d err_now=%0d, expected 8 1 9 1 1",
               nwr, nd, dc, e, err);
    end
    issue(1'b0, 32'h0000_4000, 9'd0);
    @(negedge clk);
    start = 1'b0;
    #1;
    checks++;
    if (err !== 1'b0 || done !== 1'b1) begin
      errors++;
      $display("FAIL err_clear: got err=%0d done=%0d, expected 0 1", err, done);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_read_bad_rlast();
    int nwr, nd, dc;
    logic e;
    run_read(32'h0000_5000, 4, 1, -1, 2, -1, nwr, nd, dc, e);
    checks++;
    if (nwr != 4 || nd != 1 || dc != 6 || e !== 1'b1) begin
      errors++;
      $display("FAIL read_bad_rlast: got writes=%0d dones=%0d done_cyc=%0d err=%0d, expected 4 1 6 1", nwr, nd, dc, e);
    end
  endtask

  task automatic test_zero_and_ignored_start();
    int   nwr, nd, dc;
    logic e;
    bit   activity;
    int   zdone;
    issue(1'b1, 32'h0000_6000, 9'd0);
    activity = 1'b0;
    zdone    = 0;
    for (int cyc = 0; cyc < 4; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      #1;
      activity = activity | m_axi_arvalid | m_axi_awvalid | m_axi_wvalid | loc_en;
      if (cyc == 0) begin
        checks++;
        if (done !== 1'b1 || busy !== 1'b1) begin
          errors++;
          $display("FAIL zero_beats_done: got done=%0d busy=%0d in cycle 1, expected 1 1", done, busy);
        end
      end
      if (done) zdone++;
    end
    checks++;
    if (activity || zdone != 1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL zero_beats_quiet: got activity=%0d dones=%0d busy=%0d, expected 0 1 0", activity, zdone, busy);
    end
    run_read(32'h0000_7000, 5, 3, -1, 4, 1, nwr, nd, dc, e);
    checks++;
    if (nwr != 5 || nd != 1 || dc != 9 || e !== 1'b0) begin
      errors++;
      $display("FAIL ignored_start: got writes=%0d dones=%0d done_cyc=%0d err=%0d, expected 5 1 9 0", nwr, nd, dc, e);
    end
  endtask

  task automatic test_back_to_back();
    int nw, nd, dc, fw;
    logic e;
    run_write(32'h0000_8000, 8, 1'b0, -1, nw, nd, dc, fw, e);
    checks++;
    if (nw != 8 || nd != 1 || dc != 11 || fw != 2 || e !== 1'b0) begin
      errors++;
      $display("FAIL write_stream: got beats=%0d dones=%0d done_cyc=%0d first_w_cyc=%0d err=%0d, expected 8 1 11 2 0",
               nw, nd, dc, fw, e);
    end
    run_read(32'h0000_9000, 8, 0, -1, 7, -1, nw, nd, dc, e);
    checks++;
    if (nw != 8 || nd != 1 || dc != 9 || e !== 1'b0) begin
      errors++;
      $display("FAIL read_stream: got writes=%0d dones=%0d done_cyc=%0d err=%0d, expected 8 1 9 0", nw, nd, dc, e);
    end
  endtask

  task automatic test_reset_mid_write();
    int nw, nd, dc, fw;
    logic e;
    run_write(32'h0000_a000, 16, 1'b0, 5, nw, nd, dc, fw, e);
    checks++;
    if (busy !== 1'b1 || m_axi_wvalid !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset_state: got busy=%0d wvalid=%0d, expected 1 1", busy, m_axi_wvalid);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({m_axi_wvalid, busy, loc_en, err, done, m_axi_awvalid, m_axi_bready} !== 7'b0) begin
      errors++;
      $display("FAIL async_reset: got wv,busy,en,err,done,awv,br=%b, expected 0000000", 
               {m_axi_wvalid, busy, loc_en, err, done, m_axi_awvalid, m_axi_bready});
    end
    @(negedge clk);
    rst = 1'b0;
    run_read(32'h0000_b000, 6, 0, -1, 5, -1, nw, nd, dc, e);
    checks++;
    if (nw != 6 || nd != 1 || dc != 7 || e !== 1'b0) begin
      errors++;
      $display("FAIL after_reset_cmd: got writes=%0d dones=%0d done_cyc=%0d err=%0d, expected 6 1 7 0", nw, nd, dc, e);
    end
  endtask

  initial begin
    rst           = 1'b1;
    start         = 1'b0;
    dir           = 1'b0;
    base_addr     = '0;
    beats         = '0;
    m_axi_arready = 1'b0;
    m_axi_rdata   = '0;
    m_axi_rresp   = 2'b00;
    m_axi_rlast   = 1'b0;
    m_axi_rvalid  = 1'b0;
    m_axi_awready = 1'b0;
    m_axi_wready  = 1'b0;
    m_axi_bresp   = 2'b00;
    m_axi_bvalid  = 1'b0;
    test_reset();
    test_read_burst();
    test_write_burst();
    test_read_slverr();
    test_read_bad_rlast();
    test_zero_and_ignored_start();
    test_back_to_back();
    test_reset_mid_write();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
